// File: rtl/mult_pkg.sv
// Shared definitions for the M-extension multiply issue stage:
// funct3 encodings, FSM state type and the default datapath width.
package mult_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CORRECT = 2'd2,
    S_RESP    = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_hi_correct.sv
// Turns the signed x signed high word from the multiplier into the
// MULHSU / MULHU high word; MUL and MULH pass through unchanged.
module mult_hi_correct
  import mult_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);

  logic            w_rs2_unsigned;
  logic            w_rs1_unsigned;
  logic [XLEN-1:0] w_add_rs1;
  logic [XLEN-1:0] w_add_rs2;

  assign w_rs2_unsigned = (i_funct3 == F3_MULHSU) || (i_funct3 == F3_MULHU);
  assign w_rs1_unsigned = (i_funct3 == F3_MULHU);

  // An operand read as unsigned with its MSB set is worth 2^XLEN more than
  // its signed reading, which adds the other operand into the high word.
  assign w_add_rs1 = (w_rs2_unsigned && i_rs2[XLEN-1]) ? i_rs1 : '0;
  assign w_add_rs2 = (w_rs1_unsigned && i_rs1[XLEN-1]) ? i_rs2 : '0;

  assign o_result = i_raw + w_add_rs1 + w_add_rs2;

endmodule

// File: rtl/mult_issue_ctrl.sv
// EX-stage sequencer in front of the radix-8 multiplier: latches a request,
// holds operands for MULT_LAT cycles, corrects the high word and answers.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MULT_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            resp_valid_o,
  output logic [4:0]      resp_rd_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic [XLEN-1:0] mult_oper_a_o,
  output logic [XLEN-1:0] mult_oper_b_o,
  output logic            mult_enable_o,
  output logic            mult_operation_o,
  input  logic [XLEN-1:0] mult_result_i
);

  localparam int            CW       = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MULT_LAT - 1);

  mult_state_t     r_state;
  mult_state_t     w_next;

  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_raw;
  logic [XLEN-1:0] r_oper_a;
  logic [XLEN-1:0] r_oper_b;
  logic            r_operation;
  logic [4:0]      r_resp_rd;
  logic [XLEN-1:0] r_resp_data;

  logic            r_cache_valid;
  logic [XLEN-1:0] r_cache_rs1;
  logic [XLEN-1:0] r_cache_rs2;
  logic [2:0]      r_cache_funct3;
  logic [XLEN-1:0] r_cache_data;

  logic            w_accept;
  logic            w_hit;
  logic            w_capture;
  logic            w_commit;
  logic [XLEN-1:0] w_corrected;

  assign w_accept  = (r_state == S_IDLE) && req_valid_i && !req_funct3_i[2] && !flush_i;
  assign w_hit     = r_cache_valid && (req_rs1_i == r_cache_rs1) &&
                     (req_rs2_i == r_cache_rs2) && (req_funct3_i == r_cache_funct3);
  assign w_capture = (r_state == S_ISSUE) && (r_count == LAST_CNT);
  assign w_commit  = (r_state == S_CORRECT) && !flush_i;

  mult_hi_correct #(.XLEN(XLEN)) u_hi_correct (
    .i_raw    (r_raw),
    .i_rs1    (r_rs1),
    .i_rs2    (r_rs2),
    .i_funct3 (r_funct3),
    .o_result (w_corrected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy_o        = 1'b1;
    resp_valid_o  = 1'b0;
    mult_enable_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_accept) w_next = w_hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mult_enable_o = 1'b1;
        if (flush_i)        w_next = S_IDLE;
        else if (w_capture) w_next = S_CORRECT;
      end
      S_CORRECT: w_next = flush_i ? S_IDLE : S_RESP;
      S_RESP: begin
        resp_valid_o = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, issue counter and raw product sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_raw    <= '0;
    end else begin
      if (w_accept) begin
        r_rs1    <= req_rs1_i;
        r_rs2    <= req_rs2_i;
        r_funct3 <= req_funct3_i;
        r_rd     <= req_rd_i;
      end
      r_count <= (r_state == S_ISSUE) ? r_count + 1'b1 : '0;
      if (w_capture) r_raw <= mult_result_i;
    end
  end

  // Multiplier inputs only change when a miss starts issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oper_a    <= '0;
      r_oper_b    <= '0;
      r_operation <= 1'b0;
    end else if (w_accept && !w_hit) begin
      r_oper_a    <= req_rs1_i;
      r_oper_b    <= req_rs2_i;
      r_operation <= (req_funct3_i != F3_MUL);
    end
  end

  // Response registers load on entry to RESP so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_rd      <= '0;
      r_resp_data    <= '0;
      r_cache_valid  <= 1'b0;
      r_cache_rs1    <= '0;
      r_cache_rs2    <= '0;
      r_cache_funct3 <= '0;
      r_cache_data   <= '0;
    end else if (w_commit) begin
      r_resp_rd      <= r_rd;
      r_resp_data    <= w_corrected;
      r_cache_valid  <= 1'b1;
      r_cache_rs1    <= r_rs1;
      r_cache_rs2    <= r_rs2;
      r_cache_funct3 <= r_funct3;
      r_cache_data   <= w_corrected;
    end else if (w_accept && w_hit) begin
      r_resp_rd   <= req_rd_i;
      r_resp_data <= r_cache_data;
    end
  end

  assign resp_rd_o        = r_resp_rd;
  assign resp_data_o      = r_resp_data;
  assign mult_oper_a_o    = r_oper_a;
  assign mult_oper_b_o    = r_oper_b;
  assign mult_operation_o = r_operation;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: two instances (MULT_LAT 1 and 3),
// each fed by a multiplier model that only gives a valid product on time.
module tb_mult_issue_ctrl;
  import mult_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    int          inst;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       flush;
  logic [1:0][2:0]  funct3;
  logic [1:0][31:0] rs1;
  logic [1:0][31:0] rs2;
  logic [1:0][4:0]  rd;

  wire  [1:0]       busy;
  wire  [1:0]       resp_valid;
  wire  [1:0]       mult_enable;
  wire  [1:0]       mult_operation;
  wire  [1:0][4:0]  resp_rd;
  wire  [1:0][31:0] resp_data;
  wire  [1:0][31:0] oper_a;
  wire  [1:0][31:0] oper_b;
  wire  [1:0][31:0] mult_result;

  logic [7:0] held[2]    = '{8'd0, 8'd0};
  int         en_cnt[2]  = '{0, 0};
  logic       op_seen[2] = '{1'b0, 1'b0};

  int n_cmp  = 0;
  int n_fail = 0;

  bit          cv[2];
  logic [66:0] ckey[2];

  function automatic logic [31:0] hw_mult(logic [31:0] a, logic [31:0] b, logic op);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return op ? p[63:32] : p[31:0];
  endfunction

  // Track how long operands have been presented; the product is only valid on
  // the cycle the controller is meant to sample it.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      held[i] <= mult_enable[i] ? held[i] + 8'd1 : 8'd0;
      if (mult_enable[i]) begin
        en_cnt[i]  <= en_cnt[i] + 1;
        op_seen[i] <= mult_operation[i];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    assign mult_result[g] = (mult_enable[g] && held[g] == 8'(LAT - 1)) ?
                            hw_mult(oper_a[g], oper_b[g], mult_operation[g]) : 32'hDEAD_BEEF;
    mult_issue_ctrl #(.XLEN(32), .MULT_LAT(LAT)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n[g]),
      .req_valid_i      (req_valid[g]),
      .req_funct3_i     (funct3[g]),
      .req_rs1_i        (rs1[g]),
      .req_rs2_i        (rs2[g]),
      .req_rd_i         (rd[g]),
      .flush_i          (flush[g]),
      .busy_o           (busy[g]),
      .resp_valid_o     (resp_valid[g]),
      .resp_rd_o        (resp_rd[g]),
      .resp_data_o      (resp_data[g]),
      .mult_oper_a_o    (oper_a[g]),
      .mult_oper_b_o    (oper_b[g]),
      .mult_enable_o    (mult_enable[g]),
      .mult_operation_o (mult_operation[g]),
      .mult_result_i    (mult_result[g])
    );
  end

  // Architectural result of an RV32M multiply, straight from 64-bit products.
  function automatic logic [31:0] refMul(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b};                               return p[31:0];  end
      F3_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      F3_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});       return p[63:32]; end
      default:   begin p = {32'b0, a} * {32'b0, b};                               return p[63:32]; end
    endcase
  endfunction

  function automatic void modelTxn(int idx, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                   output int lat, output logic [31:0] data);
    logic [66:0] key;
    key  = {f3, a, b};
    data = refMul(f3, a, b);
    lat  = (cv[idx] && ckey[idx] == key) ? 1 : ((idx == 0) ? LAT0 : LAT1) + 2;
    cv[idx]   = 1'b1;
    ckey[idx] = key;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkZero(int idx, string tag);
    checkOutput({tag, ".ctrl"}, {busy[idx], resp_valid[idx], mult_enable[idx],
                                 mult_operation[idx], resp_rd[idx]}, 64'd0);
    checkOutput({tag, ".data_a"}, {resp_data[idx], oper_a[idx]}, 64'd0);
    checkOutput({tag, ".oper_b"}, {32'd0, oper_b[idx]}, 64'd0);
  endtask

  task automatic applyStimulus(int idx, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                               logic [4:0] r, output int lat, output logic [31:0] data,
                               output logic [4:0] rdo, output int ens, output logic op);
    int en0;
    lat  = -1;
    data = '0;
    rdo  = '0;
    @(negedge clk);
    req_valid[idx] = 1'b1;
    funct3[idx]    = f3;
    rs1[idx]       = a;
    rs2[idx]       = b;
    rd[idx]        = r;
    en0            = en_cnt[idx];
    @(posedge clk);
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid[idx] = 1'b0;
        rs1[idx]       = $urandom;
        rs2[idx]       = $urandom;
        rd[idx]        = 5'($urandom);
      end
      if (resp_valid[idx]) begin
        lat  = n;
        data = resp_data[idx];
        rdo  = resp_rd[idx];
      end
    end
    ens = en_cnt[idx] - en0;
    op  = op_seen[idx];
  endtask

  task automatic runTxn(int idx, logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [4:0] r,
                        int exp_lat, logic [31:0] exp_data, string tag);
    int          lat, ens;
    logic [31:0] data;
    logic [4:0]  rdo;
    logic        op;
    applyStimulus(idx, f3, a, b, r, lat, data, rdo, ens, op);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, ".data"}, {32'd0, data}, {32'd0, exp_data});
    checkOutput({tag, ".rd"}, {59'd0, rdo}, {59'd0, r});
    checkOutput({tag, ".enable_cycles"}, 64'(ens),
                64'((exp_lat == 1) ? 0 : ((idx == 0) ? LAT0 : LAT1)));
    if (exp_lat != 1) checkOutput({tag, ".operation"}, {63'd0, op}, {63'd0, f3 != F3_MUL});
    @(negedge clk);
    checkOutput({tag, ".after"}, {resp_valid[idx], busy[idx], resp_data[idx]},
                {2'b00, exp_data});
  endtask

  vec_t        vecs[8];
  int          lat, lat_b, seen, en0;
  logic [31:0] exp_d, exp_b;
  logic [2:0]  rf3;
  logic [31:0] ra, rb;
  logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = '0; req_valid = '0; flush = '0; funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
    cv = '{1'b0, 1'b0};

    vecs[0] = '{0, F3_MUL,    32'd3,         32'd8,         5'd5,  3, 32'h0000_0018};
    vecs[1] = '{0, F3_MULH,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd7,  3, 32'h0000_0000};
    vecs[2] = '{0, F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  3, 32'hFFFF_FFFE};
    vecs[3] = '{0, F3_MULHSU, 32'hFFFF_FFF8, 32'h8000_0000, 5'd10, 3, 32'hFFFF_FFFC};
    vecs[4] = '{0, F3_MUL,    32'd3,         32'd8,         5'd11, 3, 32'h0000_0018};
    vecs[5] = '{0, F3_MUL,    32'd3,         32'd8,         5'd12, 1, 32'h0000_0018};
    vecs[6] = '{0, F3_MUL,    32'd3,         32'd9,         5'd13, 3, 32'h0000_001B};
    vecs[7] = '{1, F3_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd1,  5, 32'h3FFF_FFFF};

    repeat (2) @(negedge clk);
    checkZero(0, "reset0");
    checkZero(1, "reset1");
    rst_n = 2'b11;

    for (int i = 0; i < 8; i++) begin
      modelTxn(vecs[i].inst, vecs[i].f3, vecs[i].a, vecs[i].b, lat, exp_d);
      runTxn(vecs[i].inst, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].lat, vecs[i].data, $sformatf("vec%0d", i));
    end

    // funct3[2]=1 requests and requests under flush are never taken
    @(negedge clk);
    en0 = en_cnt[0];
    req_valid[0] = 1'b1; funct3[0] = 3'b101; rs1[0] = 32'd5; rs2[0] = 32'd6;
    seen = 0;
    repeat (3) begin @(negedge clk); seen += int'(busy[0]) + int'(resp_valid[0]); end
    funct3[0] = F3_MUL; flush[0] = 1'b1;
    repeat (3) begin @(negedge clk); seen += int'(busy[0]) + int'(resp_valid[0]); end
    req_valid[0] = 1'b0; flush[0] = 1'b0;
    checkOutput("ignored.busy_or_resp", 64'(seen), 64'd0);
    checkOutput("ignored.enable", 64'(en_cnt[0] - en0), 64'd0);

    // flush while ISSUE count==1 on the MULT_LAT=3 instance
    @(negedge clk);
    en0 = en_cnt[1];
    req_valid[1] = 1'b1; funct3[1] = F3_MULHU; rs1[1] = 32'h1234_5678; rs2[1] = 32'h9ABC_DEF0;
    rd[1] = 5'd20;
    @(posedge clk);
    @(negedge clk); req_valid[1] = 1'b0;
    checkOutput("flush.busy_issue", {63'd0, busy[1]}, 64'd1);
    @(negedge clk); flush[1] = 1'b1;
    @(negedge clk); flush[1] = 1'b0;
    checkOutput("flush.idle_next", {busy[1], resp_valid[1]}, 64'd0);
    seen = 0;
    repeat (6) begin @(negedge clk); seen += int'(resp_valid[1]); end
    checkOutput("flush.no_resp", 64'(seen), 64'd0);
    checkOutput("flush.enable_cycles", 64'(en_cnt[1] - en0), 64'd2);
    modelTxn(1, F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, lat, exp_d);
    runTxn(1, F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, lat, exp_d, "flush.retry");

    // a request held while busy is taken in the IDLE cycle after RESP
    modelTxn(1, F3_MUL, 32'd1000, 32'd77, lat, exp_d);
    modelTxn(1, F3_MULH, 32'h8000_0000, 32'h8000_0000, lat_b, exp_b);
    @(negedge clk);
    req_valid[1] = 1'b1; funct3[1] = F3_MUL; rs1[1] = 32'd1000; rs2[1] = 32'd77; rd[1] = 5'd2;
    @(posedge clk);
    seen = 0;
    for (int n = 1; n <= 30 && seen < 2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        funct3[1] = F3_MULH; rs1[1] = 32'h8000_0000; rs2[1] = 32'h8000_0000; rd[1] = 5'd3;
      end
      if (n == lat + 2) req_valid[1] = 1'b0;
      if (resp_valid[1]) begin
        if (seen == 0) begin
          checkOutput("b2b.first_lat", 64'(n), 64'(lat));
          checkOutput("b2b.first_data", {32'd0, resp_data[1]}, {32'd0, exp_d});
        end else begin
          checkOutput("b2b.second_lat", 64'(n), 64'(lat + 1 + lat_b));
          checkOutput("b2b.second_data", {32'd0, resp_data[1]}, {32'd0, exp_b});
          checkOutput("b2b.second_rd", {59'd0, resp_rd[1]}, 64'd3);
        end
        seen++;
      end
    end
    req_valid[1] = 1'b0;
    checkOutput("b2b.responses", 64'(seen), 64'd2);

    // reset pulse while in CORRECT clears everything including the cache
    @(negedge clk);
    req_valid[0] = 1'b1; funct3[0] = F3_MULH; rs1[0] = 32'hFFFF_FFF8; rs2[0] = 32'd7; rd[0] = 5'd4;
    @(posedge clk);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); rst_n[0] = 1'b0;
    #1 checkZero(0, "rst_mid");
    @(negedge clk); rst_n[0] = 1'b1;
    cv[0] = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); seen += int'(resp_valid[0]); end
    checkOutput("rst_mid.no_resp", 64'(seen), 64'd0);
    modelTxn(0, F3_MUL, 32'd3, 32'd9, lat, exp_d);
    runTxn(0, F3_MUL, 32'd3, 32'd9, 5'd14, lat, exp_d, "rst_mid.miss");

    // randomized traffic, with deliberate repeats to exercise the cache
    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = int'($urandom_range(0, 1));
      if (cv[idx] && $urandom_range(0, 3) == 0) begin
        rf3 = ckey[idx][66:64]; ra = ckey[idx][63:32]; rb = ckey[idx][31:0];
      end else begin
        rf3 = 3'($urandom_range(0, 3));
        ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
        rb  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      end
      modelTxn(idx, rf3, ra, rb, lat, exp_d);
      runTxn(idx, rf3, ra, rb, 5'($urandom), lat, exp_d, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Sequencing stage directly upstream of mult_radix8_top in the EX stage of the RV32IM core.
- Accepts M-extension multiply requests (MUL/MULH/MULHSU/MULHU) from decode and registers the operands.
- Drives the multiplier's oper_a/oper_b/enable_mult/operation inputs, waits a fixed latency, then captures mult_o.
- Applies unsigned-high correction for MULHSU/MULHU, stalls the pipeline while busy, and keeps a one-entry result cache for back-to-back identical requests.

Parameters:
- XLEN, 32, operand/result width.
- MULT_LAT, 1, cycles operands are held at the multiplier before mult_o is sampled (≥1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  decode presents a multiply request.
- req_funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx never accepted.
- req_rs1_i  in  XLEN  rs1 value.
- req_rs2_i  in  XLEN  rs2 value.
- req_rd_i  in  5  destination register.
- flush_i  in  1  pipeline flush; aborts the in-flight op.
- busy_o  out  1  stall to pipeline.
- resp_valid_o  out  1  one-cycle result strobe.
- resp_rd_o  out  5  destination for the result.
- resp_data_o  out  XLEN  result.
- mult_oper_a_o  out  XLEN  to multiplier oper_a.
- mult_oper_b_o  out  XLEN  to multiplier oper_b.
- mult_enable_o  out  1  to multiplier enable_mult.
- mult_operation_o  out  1  to multiplier operation: 0 = low word, 1 = high word.
- mult_result_i  in  XLEN  from multiplier mult_o (signed×signed, selected half).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; operand/rd/count registers 0; cache valid bit cleared.
- FSM states: IDLE, ISSUE, CORRECT, RESP.
- IDLE:
  - Accept when req_valid_i=1 and funct3[2]=0 and flush_i=0; latch rs1, rs2, funct3, rd.
  - Cache hit (cache valid and {rs1,rs2,funct3} equal to cached): go to RESP with the cached data.
  - Otherwise go to ISSUE with count=0.
  - Requests with funct3[2]=1 are ignored.
- ISSUE:
  - mult_enable_o=1; mult_oper_a_o/mult_oper_b_o = latched operands; mult_operation_o = (funct3 != 000).
  - count increments each cycle.
  - On the cycle count==MULT_LAT-1, capture mult_result_i into raw and go to CORRECT.
  - In all other states mult_enable_o=0 and operands are held at their last value.
- CORRECT: one cycle, registers the corrected result.
  - MUL, MULH: result = raw.
  - MULHSU: result = raw + (rs2[XLEN-1] ? rs1 : 0).
  - MULHU: result = raw + (rs1[XLEN-1] ? rs2 : 0) + (rs2[XLEN-1] ? rs1 : 0).
  - All additions are modulo 2^XLEN.
  - Cache updated with {rs1,rs2,funct3,result}; valid set.
- RESP: resp_valid_o=1 for exactly one cycle with resp_rd_o and resp_data_o; next state IDLE.
- resp_rd_o/resp_data_o hold their value after RESP until the next response.
- Latency from accept edge to resp_valid_o:
  - Miss: MULT_LAT+2 cycles.
  - Hit: 1 cycle.
- busy_o = (state != IDLE). A request arriving while busy is not accepted; the requester holds it until busy_o=0.
- Back-to-back: a new request is accepted in the IDLE cycle that follows RESP (no same-cycle accept in RESP).
- flush_i:
  - In ISSUE or CORRECT: next state IDLE, no response, cache not updated.
  - In RESP: the response still completes (already committed).
  - In IDLE: blocks acceptance.
  - The cache is retained across flush.
- Reset asserted mid-operation: immediate return to reset values, no response, cache invalid.

Decomposition:
- Package mult_pkg:
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - State enum mult_state_t.
  - XLEN default.
- Sub-module mult_hi_correct: combinational correction adder.
  - Inputs: raw, rs1, rs2, funct3. Output: corrected result.
  - Unit-testable in isolation.

Test Plan:
- MUL rs1=3, rs2=8, MULT_LAT=1 → mult_enable_o high 1 cycle with operation=0; resp_valid_o 3 cycles after accept; resp_data_o=0x00000018; resp_rd_o echoes req_rd_i.
- MULH rs1=0xFFFFFFF8 (−8), rs2=0xFFFFFFFD (−3) → operation=1; resp_data_o=0x00000000.
- MULHU rs1=rs2=0xFFFFFFFF (bench multiplier model returns signed high 0) → resp_data_o=0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFF8, rs2=0x80000000 (signed high 0x00000004) → resp_data_o=0xFFFFFFFC.
- Repeat MUL 3×8 immediately → resp_valid_o 1 cycle after accept with 0x18; mult_enable_o never asserted; then MUL 3×9 → miss, full latency, 0x1B.
- Flush mid-ISSUE (MULT_LAT=3, flush on count=1) → no resp_valid_o; busy_o low next cycle; a following identical request misses the cache. Separately, rst_n pulsed low mid-CORRECT → all outputs 0 immediately; no response.
